// File: rtl/uart_rx_163.sv
// uart_rx_163: 8N1 UART receiver with mid-bit sampling.
// Framing errors hold the receiver in BREAK until the line returns high.
module uart_rx_163 #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bidx_q;
  logic [7:0]      sh_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            ferr_q;
  logic            busy_q;
  logic            sync1_q;
  logic            sync2_q;
  logic            rxd_s;

  assign rxd_s = sync2_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // busy tracks the next state so it drops in the same cycle as valid
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxd_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rxd_s) begin
              state_q <= DATA;
              bidx_q  <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            sh_q  <= {rxd_s, sh_q[7:1]};
            if (bidx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bidx_q <= bidx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rxd_s) begin
              data_q  <= sh_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BRK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BRK: begin
          cnt_q <= '0;
          if (rxd_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_163.sv
// tb_uart_rx_163: scoreboard bench for uart_rx_163.
// Two instances: DIV=16 and DIV=17 (odd, skewed transmitter).
`timescale 1ns/1ps
module tb_uart_rx_163;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       rxd16 = 1'b1;
  logic       rxd17 = 1'b1;
  logic [7:0] d16, d17;
  logic       v16, v17, fe16, fe17, b16, b17;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  byte unsigned q16[$];
  byte unsigned q17[$];
  byte unsigned e16, e17;
  int vt16[$];
  int vcnt16 = 0, vcnt17 = 0;
  int fcnt16 = 0, fcnt17 = 0;
  logic pv16 = 1'b0, pv17 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_163 #(.DIV(16)) u16 (
    .clk(clk), .clr_n(clr_n), .rxd(rxd16),
    .data(d16), .valid(v16), .frame_err(fe16), .busy(b16)
  );

  uart_rx_163 #(.DIV(17)) u17 (
    .clk(clk), .clr_n(clr_n), .rxd(rxd17),
    .data(d17), .valid(v17), .frame_err(fe17), .busy(b17)
  );

  always @(negedge clk) begin
    if (v16) begin
      total++;
      if (q16.size() == 0) begin
        bad++;
        $display("FAIL sb16_unexpected: got valid data=%h, required no valid", d16);
      end else begin
        e16 = q16.pop_front();
        if (d16 !== e16) begin
          bad++;
          $display("FAIL sb16_data: got %h, required %h", d16, e16);
        end
      end
      vcnt16++;
      vt16.push_back(cyc);
    end
    if (fe16) fcnt16++;
    if (v16 || fe16) begin
      total++;
      if ((v16 && fe16) || pv16) begin
        bad++;
        $display("FAIL pulse16: got v=%b fe=%b prev=%b, required single exclusive pulse",
                 v16, fe16, pv16);
      end
    end
    pv16 = v16 | fe16;
  end

  always @(negedge clk) begin
    if (v17) begin
      total++;
      if (q17.size() == 0) begin
        bad++;
        $display("FAIL sb17_unexpected: got valid data=%h, required no valid", d17);
      end else begin
        e17 = q17.pop_front();
        if (d17 !== e17) begin
          bad++;
          $display("FAIL sb17_data: got %h, required %h", d17, e17);
        end
      end
      vcnt17++;
    end
    if (fe17) fcnt17++;
    if (v17 || fe17) begin
      total++;
      if ((v17 && fe17) || pv17) begin
        bad++;
        $display("FAIL pulse17: got v=%b fe=%b prev=%b, required single exclusive pulse",
                 v17, fe17, pv17);
      end
    end
    pv17 = v17 | fe17;
  end

  task automatic drive(input int which, input logic v);
    if (which == 16) rxd16 = v;
    else rxd17 = v;
  endtask

  task automatic send(input int which, input logic [7:0] b, input logic stop,
                      input real per, input bit exp_ok);
    real bt;
    bt = per * 10.0;
    if (exp_ok) begin
      if (which == 16) q16.push_back(b);
      else q17.push_back(b);
    end
    drive(which, 1'b0);
    #bt;
    for (int i = 0; i < 8; i++) begin
      drive(which, b[i]);
      #bt;
    end
    drive(which, stop);
    #bt;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 6;
    if (d16 !== 8'h00) begin bad++; $display("FAIL rst_data16: got %h, required 00", d16); end
    if (v16 !== 1'b0) begin bad++; $display("FAIL rst_valid16: got %b, required 0", v16); end
    if (fe16 !== 1'b0) begin bad++; $display("FAIL rst_ferr16: got %b, required 0", fe16); end
    if (b16 !== 1'b0) begin bad++; $display("FAIL rst_busy16: got %b, required 0", b16); end
    if (d17 !== 8'h00) begin bad++; $display("FAIL rst_data17: got %h, required 00", d17); end
    if (b17 !== 1'b0) begin bad++; $display("FAIL rst_busy17: got %b, required 0", b17); end
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame_a5();
    int t0, n0, f0, lows, lat;
    bit done;
    @(negedge clk);
    t0 = cyc; n0 = vcnt16; f0 = fcnt16; lows = 0; done = 0;
    fork
      send(16, 8'hA5, 1'b1, 16.0, 1'b1);
      begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 200 && !done; i++) begin
          @(posedge clk);
          #1;
          if (v16) done = 1;
          else if (!b16) lows++;
        end
      end
    join
    total += 6;
    if (vcnt16 !== n0 + 1) begin
      bad++; $display("FAIL a5_count: got %0d valids, required 1", vcnt16 - n0);
    end
    lat = (vt16.size() > 0) ? vt16[vt16.size() - 1] - t0 : -1;
    if (lat < 153 || lat > 157) begin
      bad++; $display("FAIL a5_latency: got %0d cycles, required 153..157", lat);
    end
    if (lows != 0 || !done) begin
      bad++; $display("FAIL a5_busy: got %0d low cycles done=%b, required 0 and 1", lows, done);
    end
    if (fcnt16 !== f0) begin
      bad++; $display("FAIL a5_ferr: got %0d, required 0", fcnt16 - f0);
    end
    if (d16 !== 8'hA5) begin
      bad++; $display("FAIL a5_data: got %h, required a5", d16);
    end
    if (b16 !== 1'b0) begin
      bad++; $display("FAIL a5_idle: got busy %b, required 0", b16);
    end
  endtask

  task automatic test_back_to_back();
    int n0, s1, s2;
    @(negedge clk);
    n0 = vcnt16;
    send(16, 8'h00, 1'b1, 16.0, 1'b1);
    send(16, 8'hFF, 1'b1, 16.0, 1'b1);
    send(16, 8'h3C, 1'b1, 16.0, 1'b1);
    for (int i = 0; i < 40 && vcnt16 < n0 + 3; i++) @(negedge clk);
    total += 3;
    if (vcnt16 !== n0 + 3) begin
      bad++; $display("FAIL b2b_count: got %0d valids, required 3", vcnt16 - n0);
    end
    s1 = -1; s2 = -1;
    if (vt16.size() >= n0 + 3) begin
      s1 = vt16[n0 + 1] - vt16[n0];
      s2 = vt16[n0 + 2] - vt16[n0 + 1];
    end
    if (s1 != 160 || s2 != 160) begin
      bad++; $display("FAIL b2b_spacing: got %0d,%0d, required 160,160", s1, s2);
    end
    if (d16 !== 8'h3C) begin
      bad++; $display("FAIL b2b_last: got %h, required 3c", d16);
    end
  endtask

  task automatic test_frame_error();
    int n0, f0;
    @(negedge clk);
    n0 = vcnt16; f0 = fcnt16;
    send(16, 8'h55, 1'b0, 16.0, 1'b0);
    repeat (40) @(negedge clk);
    total += 4;
    if (fcnt16 !== f0 + 1) begin
      bad++; $display("FAIL ferr_count: got %0d, required 1", fcnt16 - f0);
    end
    if (vcnt16 !== n0) begin
      bad++; $display("FAIL ferr_novalid: got %0d valids, required 0", vcnt16 - n0);
    end
    if (d16 !== 8'h3C) begin
      bad++; $display("FAIL ferr_data: got %h, required 3c", d16);
    end
    if (b16 !== 1'b1) begin
      bad++; $display("FAIL ferr_break_busy: got %b, required 1", b16);
    end
    rxd16 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (b16 !== 1'b1) begin
      bad++; $display("FAIL ferr_busy_hold: got %b, required 1", b16);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (b16 !== 1'b0) begin
      bad++; $display("FAIL ferr_busy_release: got %b, required 0", b16);
    end
  endtask

  task automatic test_glitch();
    int n0, f0;
    @(negedge clk);
    n0 = vcnt16; f0 = fcnt16;
    rxd16 = 1'b0;
    repeat (5) @(negedge clk);
    rxd16 = 1'b1;
    total++;
    if (b16 !== 1'b1) begin
      bad++; $display("FAIL glitch_seen: got busy %b, required 1", b16);
    end
    repeat (11) @(negedge clk);
    total++;
    if (b16 !== 1'b0) begin
      bad++; $display("FAIL glitch_idle: got busy %b, required 0", b16);
    end
    repeat (20) @(negedge clk);
    total++;
    if (vcnt16 !== n0 || fcnt16 !== f0) begin
      bad++; $display("FAIL glitch_quiet: got v=%0d fe=%0d, required 0,0",
                      vcnt16 - n0, fcnt16 - f0);
    end
  endtask

  task automatic test_reset_midframe();
    int n0, f0;
    @(negedge clk);
    n0 = vcnt16; f0 = fcnt16;
    fork
      send(16, 8'hF0, 1'b1, 16.0, 1'b0);
      begin
        repeat (88) @(negedge clk);
        clr_n = 1'b0;
        #1;
        total += 4;
        if (d16 !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h, required 00", d16); end
        if (v16 !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b, required 0", v16); end
        if (fe16 !== 1'b0) begin bad++; $display("FAIL mid_rst_ferr: got %b, required 0", fe16); end
        if (b16 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b, required 0", b16); end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    total++;
    if (vcnt16 !== n0 || fcnt16 !== f0) begin
      bad++; $display("FAIL mid_abort_quiet: got v=%0d fe=%0d, required 0,0",
                      vcnt16 - n0, fcnt16 - f0);
    end
    @(negedge clk);
    send(16, 8'h81, 1'b1, 16.0, 1'b1);
    repeat (10) @(negedge clk);
    total += 2;
    if (vcnt16 !== n0 + 1) begin
      bad++; $display("FAIL mid_recover_count: got %0d, required 1", vcnt16 - n0);
    end
    if (d16 !== 8'h81) begin
      bad++; $display("FAIL mid_recover_data: got %h, required 81", d16);
    end
  endtask

  task automatic test_odd_div();
    int n0;
    @(negedge clk);
    n0 = vcnt17;
    send(17, 8'h96, 1'b1, 16.5, 1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (vcnt17 !== n0 + 1 || d17 !== 8'h96) begin
      bad++; $display("FAIL odd_fast: got n=%0d data=%h, required 1 96", vcnt17 - n0, d17);
    end
    send(17, 8'h96, 1'b1, 17.5, 1'b1);
    repeat (20) @(negedge clk);
    total += 2;
    if (vcnt17 !== n0 + 2 || d17 !== 8'h96) begin
      bad++; $display("FAIL odd_slow: got n=%0d data=%h, required 2 96", vcnt17 - n0, d17);
    end
    if (fcnt17 !== 0) begin
      bad++; $display("FAIL odd_ferr: got %0d, required 0", fcnt17);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_odd_div();
    repeat (5) @(negedge clk);
    total++;
    if (q16.size() != 0 || q17.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d/%0d pending, required 0/0", q16.size(), q17.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_163.md
# uart_rx_163

UART receive block, the inbound counterpart to the team's transmit path built around the sn74ls163a-style counter. It recovers 8N1 frames from an asynchronous serial line using an internal clocks-per-bit counter with mid-bit sampling, and presents each received byte with a one-cycle valid strobe. It also flags framing errors. It sits between the external RXD pin and the byte-level consumer logic.

## Interface
- DIV, 434: clocks per bit period (e.g. 50 MHz / 115200); legal range 4..65535; DIV/2 uses integer division.
- clk  input  1  system clock; all state changes on rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last correctly received byte; LSB received first.
- valid  output  1  one-cycle pulse: data updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

## Operation
- Input path: rxd passes through a 2-flop synchronizer (reset value 1) to give rxd_s; the FSM uses only rxd_s.
- Bit counter cnt: width ceil(log2(DIV)); counts 0..DIV-1; cleared on every state entry.
- Bit index bidx: 3 bits. Shift register sh: 8 bits; right-shift, new bit enters at bit 7.
- State machine:
  - IDLE: when rxd_s=0, go to START with cnt=0.
  - START: cnt increments. At cnt=DIV/2-1, sample rxd_s. If 0, go to DATA with cnt=0 and bidx=0. If 1, treat as a glitch and return to IDLE with no flag.
  - DATA: at cnt=DIV-1, shift rxd_s into sh and set cnt=0. When bidx=7, go to STOP; otherwise increment bidx.
  - STOP: at cnt=DIV-1, sample rxd_s.
    - If 1: data<=sh, pulse valid, go to IDLE.
    - If 0: pulse frame_err, leave data unchanged, go to BREAK.
  - BREAK: stay until rxd_s=1, then go to IDLE.
- Because of the START half-period offset, every data and stop sample lands mid-bit.
- valid and frame_err are never high in the same cycle.
- A new start edge is accepted in the first IDLE cycle after valid. Back-to-back frames with no extra idle time are received without loss.
- Reset values: data=0x00, valid=0, frame_err=0, busy=0, state=IDLE, cnt=0, bidx=0, sh=0x00, synchronizer flops=1.
- Reset mid-frame: all state is abandoned immediately, and no valid or frame_err is produced for the interrupted frame. After release, the remainder of that frame is treated as ordinary line activity: a low level restarts START.

## Timing
- From the first clk edge that captures rxd low into synchronizer flop 1:
  - rxd_s goes low after 2 cycles.
  - START is entered after 3 cycles.
  - Data bit k is sampled at 3 + DIV/2 + (k+1)·DIV cycles.
  - valid (or frame_err) rises at 3 + DIV/2 + 9·DIV + 1 cycles, i.e. 9.5·DIV + 4 for even DIV, ±1 for the asynchronous edge position.
- valid and frame_err are registered, and each lasts exactly 1 cycle.
- data is stable from the valid cycle until the next valid.
- busy is registered from state: it rises the cycle after IDLE exits and falls in the cycle valid is asserted.
- Glitch rejection: a low pulse on rxd shorter than DIV/2-1 cycles returns the FSM to IDLE with no output.
- Required receiver tolerance: correct reception with a transmitter bit period within ±3% of DIV.

## Test plan
- DIV=16, send 0xA5 as an 8N1 frame (stop=1) → exactly one valid pulse, data=0xA5, frame_err never high, busy high for the whole frame.
- DIV=16, frames 0x00, 0xFF, 0x3C back-to-back with no extra idle → three valid pulses with data 0x00, 0xFF, 0x3C in order, spaced 10·DIV cycles apart.
- DIV=16, send 0x55 with the stop bit forced 0, then hold rxd low for 40 cycles, then release high → one frame_err pulse, no valid, data keeps its previous value, and busy stays high until 2–3 cycles after rxd rises.
- DIV=16, 5-cycle low glitch on rxd → no valid, no frame_err; FSM back in IDLE (busy=0) within DIV/2+3 cycles.
- DIV=16, assert clr_n=0 during bit 4 of a frame, release 2 cycles later, then send 0x81 → all outputs read reset values during reset and no pulse for the aborted frame. The 0x81 frame is then received correctly, after the remainder of the aborted frame has been rejected or has ended in BREAK and recovered.
- DIV=17 (odd), transmitter bit period 16.5 and 17.5 cycles, send 0x96 → data=0x96 with valid in both cases.
